// File: rtl/chimera_pkg.sv
// Shared types and defaults for the Chimera cluster power sequencer.
// Holds the per-cluster state enum, output bundle and state decoder.
package chimera_pkg;

  localparam int unsigned ExtClusters      = 5;
  localparam int unsigned DefSettleCycles  = 4;
  localparam int unsigned DefRstCycles     = 8;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [2:0] {
    CLU_OFF,
    CLU_CLK_ON,
    CLU_RST_REL,
    CLU_DEISO,
    CLU_ACTIVE,
    CLU_ISO,
    CLU_RST_ON,
    CLU_CLK_OFF
  } clu_pwr_state_e;

  typedef struct packed {
    logic clk_en;
    logic rst_n;
    logic isolate;
    logic active;
    logic busy;
  } clu_pwr_out_t;

  function automatic int unsigned clu_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Output levels seen by the cluster while the FSM sits in state s.
  function automatic clu_pwr_out_t clu_pwr_decode(clu_pwr_state_e s);
    clu_pwr_out_t o;
    o = '{clk_en: 1'b0, rst_n: 1'b0, isolate: 1'b1,
          active: 1'b0, busy: 1'b1};
    unique case (s)
      CLU_OFF: o.busy = 1'b0;
      CLU_CLK_ON: o.clk_en = 1'b1;
      CLU_RST_REL: begin
        o.clk_en = 1'b1;
        o.rst_n  = 1'b1;
      end
      CLU_DEISO: begin
        o.clk_en  = 1'b1;
        o.rst_n   = 1'b1;
        o.isolate = 1'b0;
      end
      CLU_ACTIVE: begin
        o.clk_en  = 1'b1;
        o.rst_n   = 1'b1;
        o.isolate = 1'b0;
        o.active  = 1'b1;
        o.busy    = 1'b0;
      end
      CLU_ISO: begin
        o.clk_en = 1'b1;
        o.rst_n  = 1'b1;
      end
      CLU_RST_ON: o.clk_en = 1'b1;
      CLU_CLK_OFF: begin
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// One cluster's power/reset/isolation sequencer with its own counter.
// Ports: clk/rst, en/bypass/isolated requests in; clock enable, active-low
// reset, isolate, latched bypass, active/busy/timeout status out.
// CHIMERA_CLU_PWR_TIMEOUT_EN adds a handshake timeout in DEISO and ISO.
module chimera_clu_pwr_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned SettleCycles  = DefSettleCycles,
  parameter int unsigned RstCycles     = DefRstCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic bypass_i,
  input  logic isolated_i,
  output logic clk_en_o,
  output logic rst_no,
  output logic isolate_o,
  output logic bypass_o,
  output logic active_o,
  output logic busy_o,
  output logic timeout_o
);

`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
  localparam int unsigned CntMax =
    clu_max(clu_max(SettleCycles, RstCycles), TimeoutCycles);
`else
  localparam int unsigned CntMax = clu_max(SettleCycles, RstCycles);
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] RstLast    = CntW'(RstCycles - 1);

  if (SettleCycles < 1 || RstCycles < 1 || TimeoutCycles < 1) begin : g_bad_cfg
    $error("chimera_clu_pwr_fsm: cycle parameters must be >= 1");
  end

  clu_pwr_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bypass_q, bypass_d;
  clu_pwr_out_t    out_q, out_d;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
  localparam logic [CntW-1:0] ToLast = CntW'(TimeoutCycles - 1);
  logic            to_q, to_d;
`endif

  always_comb begin
    state_d  = state_q;
    bypass_d = bypass_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
    to_d     = to_q;
`endif
    unique case (state_q)
      CLU_OFF: begin
        if (en_i) begin
          state_d  = CLU_CLK_ON;
          bypass_d = bypass_i;
        end
      end
      CLU_CLK_ON: begin
        if (cnt_q == SettleLast) state_d = CLU_RST_REL;
      end
      CLU_RST_REL: begin
        if (cnt_q == RstLast) state_d = CLU_DEISO;
      end
      CLU_DEISO: begin
        if (!isolated_i) state_d = CLU_ACTIVE;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
        else if (cnt_q == ToLast) begin
          state_d = CLU_ACTIVE;
          to_d    = 1'b1;
        end
`endif
      end
      CLU_ACTIVE: begin
        if (!en_i) state_d = CLU_ISO;
      end
      CLU_ISO: begin
        if (isolated_i) state_d = CLU_RST_ON;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
        else if (cnt_q == ToLast) begin
          state_d = CLU_RST_ON;
          to_d    = 1'b1;
        end
`endif
      end
      CLU_RST_ON: begin
        if (cnt_q == RstLast) state_d = CLU_CLK_OFF;
      end
      CLU_CLK_OFF: state_d = CLU_OFF;
    endcase
    // Every state counts its own dwell time from zero.
    if (state_d != state_q) cnt_d = '0;
    // Outputs are decoded from the next state so they leave the flops
    // in the same cycle the state does.
    out_d = clu_pwr_decode(state_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= CLU_OFF;
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      out_q    <= clu_pwr_decode(CLU_OFF);
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bypass_q <= bypass_d;
      out_q    <= out_d;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  assign clk_en_o  = out_q.clk_en;
  assign rst_no    = out_q.rst_n;
  assign isolate_o = out_q.isolate;
  assign active_o  = out_q.active;
  assign busy_o    = out_q.busy;
  assign bypass_o  = bypass_q;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/chimera_clu_pwr_ctrl.sv
// Per-cluster power/reset sequencer: fans request vectors out to one FSM
// per cluster and gathers clock/reset/isolation/status vectors back.
// Optional macro: CHIMERA_CLU_PWR_TIMEOUT_EN (isolation handshake timeout).
module chimera_clu_pwr_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters   = ExtClusters,
  parameter int unsigned SettleCycles  = DefSettleCycles,
  parameter int unsigned RstCycles     = DefRstCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] en_i,
  input  logic [NumClusters-1:0] widemem_bypass_i,
  input  logic [NumClusters-1:0] isolated_i,
  output logic [NumClusters-1:0] clu_clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] widemem_bypass_o,
  output logic [NumClusters-1:0] active_o,
  output logic [NumClusters-1:0] busy_o,
  output logic [NumClusters-1:0] timeout_o
);

  for (genvar g = 0; g < NumClusters; g++) begin : g_clu
    chimera_clu_pwr_fsm #(
      .SettleCycles (SettleCycles),
      .RstCycles    (RstCycles),
      .TimeoutCycles(TimeoutCycles)
    ) u_fsm (
      .clk_i     (soc_clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i[g]),
      .bypass_i  (widemem_bypass_i[g]),
      .isolated_i(isolated_i[g]),
      .clk_en_o  (clu_clk_en_o[g]),
      .rst_no    (clu_rst_no[g]),
      .isolate_o (isolate_o[g]),
      .bypass_o  (widemem_bypass_o[g]),
      .active_o  (active_o[g]),
      .busy_o    (busy_o[g]),
      .timeout_o (timeout_o[g])
    );
  end

endmodule

// File: tb/tb_chimera_clu_pwr_ctrl.sv
// Directed bench for chimera_clu_pwr_ctrl (5 clusters, 4/8/16 cycles).
// Vector tables for the up/down timelines plus hand-written corner cases.
module tb_chimera_clu_pwr_ctrl;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en, byp_in, iso_ack;
  logic [N-1:0] clk_en, rst_n, iso, byp_out, act, busy, tmo;

  always #5 clk = ~clk;

  chimera_clu_pwr_ctrl #(
    .NumClusters  (N),
    .SettleCycles (4),
    .RstCycles    (8),
    .TimeoutCycles(16)
  ) dut (
    .soc_clk_i       (clk),
    .rst_i           (rst),
    .en_i            (en),
    .widemem_bypass_i(byp_in),
    .isolated_i      (iso_ack),
    .clu_clk_en_o    (clk_en),
    .clu_rst_no      (rst_n),
    .isolate_o       (iso),
    .widemem_bypass_o(byp_out),
    .active_o        (act),
    .busy_o          (busy),
    .timeout_o       (tmo)
  );

  // {clk_en, rst_n, isolate, active, busy} of one cluster
  typedef struct {
    string      nm;
    int         cl;
    int         off;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] S_OFF    = 5'b00100;
  localparam logic [4:0] S_CLKON  = 5'b10101;
  localparam logic [4:0] S_RSTREL = 5'b11101;
  localparam logic [4:0] S_DEISO  = 5'b11001;
  localparam logic [4:0] S_ACTIVE = 5'b11010;
  localparam logic [4:0] S_ISO    = 5'b11101;
  localparam logic [4:0] S_RSTON  = 5'b10101;
  localparam logic [4:0] S_CLKOFF = 5'b00101;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base;

  logic [N-1:0] lag0, lag1, lag2, follow, iso_man;
  int           rise_at[N];
  vec_t         up_v[$];
  vec_t         dn_v[$];

  localparam logic [7*N-1:0] RST_VEC = {
    {N{1'b0}}, {N{1'b0}}, {N{1'b1}}, {N{1'b0}},
    {N{1'b0}}, {N{1'b0}}, {N{1'b0}}
  };

  function automatic logic [4:0] bits(int c);
    return {clk_en[c], rst_n[c], iso[c], act[c], busy[c]};
  endfunction

  function automatic logic [7*N-1:0] all_outs();
    return {clk_en, rst_n, iso, byp_out, act, busy, tmo};
  endfunction

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Clusters in follow mode see isolate_o echoed back two cycles late;
  // the others see iso_man, which can be raised at a scheduled cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    lag2 = lag1;
    lag1 = lag0;
    lag0 = iso;
    for (int i = 0; i < N; i++)
      if (rise_at[i] == cyc) iso_man[i] = 1'b1;
    iso_ack = (lag2 & follow) | (iso_man & ~follow);
  endtask

  task automatic run_vecs(input vec_t v[$], input int b);
    foreach (v[k]) begin
      while (cyc < b + v[k].off) step();
      check(v[k].nm, 64'(bits(v[k].cl)), 64'(v[k].exp));
    end
  endtask

  task automatic wait_active(string nm, int cl, int budget);
    for (int k = 0; k < budget && act[cl] !== 1'b1; k++) step();
    n_tests++;
    if (act[cl] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: active_o[%0d] got %b want 1 within %0d cycles",
               nm, cl, act[cl], budget);
    end
  endtask

  task automatic wait_off(string nm, int cl, int budget);
    for (int k = 0; k < budget && (busy[cl] !== 1'b0 || act[cl] !== 1'b0); k++)
      step();
    n_tests++;
    if (busy[cl] !== 1'b0 || act[cl] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cluster %0d busy=%b active=%b want 0/0 in %0d cycles",
               nm, cl, busy[cl], act[cl], budget);
    end
  endtask

  initial begin
    up_v = '{
      '{"up_c10_off",    0,  0, S_OFF},
      '{"up_c11_clkon",  0,  1, S_CLKON},
      '{"up_c14_clkon",  0,  4, S_CLKON},
      '{"up_c15_rstrel", 0,  5, S_RSTREL},
      '{"up_c22_rstrel", 0, 12, S_RSTREL},
      '{"up_c23_deiso",  0, 13, S_DEISO},
      '{"up_c25_deiso",  0, 15, S_DEISO},
      '{"up_c26_active", 0, 16, S_ACTIVE}
    };
    dn_v = '{
      '{"dn_iso",     0,  1, S_ISO},
      '{"dn_iso_ack", 0,  6, S_ISO},
      '{"dn_rston",   0,  7, S_RSTON},
      '{"dn_rston_l", 0, 14, S_RSTON},
      '{"dn_clkoff",  0, 15, S_CLKOFF},
      '{"dn_off",     0, 16, S_OFF}
    };

    rst     = 1'b1;
    en      = '0;
    byp_in  = '0;
    follow  = '1;
    iso_man = '0;
    lag0    = '1;
    lag1    = '1;
    lag2    = '1;
    iso_ack = '1;
    for (int i = 0; i < N; i++) rise_at[i] = -1;

    repeat (3) @(posedge clk);
    #2;
    check("reset_vals", 64'(all_outs()), 64'(RST_VEC));
    #1 rst = 1'b0;
    cyc = 0;

    // power-up timeline of cluster 0
    while (cyc < 10) step();
    base  = cyc;
    en[0] = 1'b1;
    run_vecs(up_v, base);
    check("others_idle", 64'(clk_en[N-1:1]), 64'(0));

    // power-down with a 5-cycle late acknowledge
    follow[0]  = 1'b0;
    iso_man[0] = 1'b0;
    step();
    base       = cyc;
    en[0]      = 1'b0;
    rise_at[0] = base + 6;
    run_vecs(dn_v, base);
    follow[0]  = 1'b1;
    rise_at[0] = -1;

    // bypass latch on cluster 1
    byp_in[1] = 1'b1;
    en[1]     = 1'b1;
    wait_active("byp_up", 1, 40);
    check("byp_latched", 64'(byp_out[1]), 64'(1));
    byp_in[1] = 1'b0;
    repeat (3) step();
    check("byp_hold_active", 64'(byp_out[1]), 64'(1));
    en[1] = 1'b0;
    wait_off("byp_dn", 1, 60);
    check("byp_hold_off", 64'(byp_out[1]), 64'(1));
    en[1] = 1'b1;
    step();
    check("byp_relatch", 64'({clk_en[1], byp_out[1]}), 64'(2'b10));
    en[1] = 1'b0;
    wait_active("byp_up2", 1, 40);
    wait_off("byp_dn2", 1, 60);

    // one-cycle enable pulse on cluster 2
    en[2] = 1'b1;
    step();
    en[2] = 1'b0;
    check("tog_clkon", 64'(bits(2)), 64'(S_CLKON));
    step();
    check("tog_ignored", 64'(bits(2)), 64'(S_CLKON));
    wait_active("tog_up", 2, 40);
    step();
    check("tog_iso", 64'(bits(2)), 64'(S_ISO));
    wait_off("tog_dn", 2, 60);
    check("tog_off", 64'(bits(2)), 64'(S_OFF));

    // isolation acknowledge stuck low on cluster 3
    follow[3]  = 1'b0;
    iso_man[3] = 1'b0;
    en[3]      = 1'b1;
    wait_active("to_up", 3, 40);
    en[3] = 1'b0;
    step();
    base = cyc;
    check("to_iso", 64'(bits(3)), 64'(S_ISO));
    while (cyc < base + 15) step();
    check("to_pre", 64'({tmo[3], bits(3)}), 64'({1'b0, S_ISO}));
    step();
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
    check("to_fire", 64'({tmo[3], bits(3)}), 64'({1'b1, S_RSTON}));
    wait_off("to_dn", 3, 40);
    check("to_sticky", 64'(tmo[3]), 64'(1));
`else
    check("to_wait", 64'({tmo[3], bits(3)}), 64'({1'b0, S_ISO}));
    repeat (24) step();
    check("to_wait_long", 64'({tmo[3], bits(3)}), 64'({1'b0, S_ISO}));
    iso_man[3] = 1'b1;
    wait_off("to_dn", 3, 40);
    check("to_none", 64'(tmo[3]), 64'(0));
`endif
    follow[3] = 1'b1;

    // async reset while every cluster sits in RST_REL
    step();
    base = cyc;
    en   = '1;
    while (cyc < base + 7) step();
    check("all_rstrel", 64'({clk_en, rst_n, iso, busy}),
          64'({{N{1'b1}}, {N{1'b1}}, {N{1'b1}}, {N{1'b1}}}));
    #2 rst = 1'b1;
    #1;
    check("async_rst", 64'(all_outs()), 64'(RST_VEC));
    #1 rst = 1'b0;
    step();
    check("restart", 64'({clk_en, rst_n, busy}),
          64'({{N{1'b1}}, {N{1'b0}}, {N{1'b1}}}));
    for (int i = 0; i < N; i++) wait_active("all_up", i, 40);
    en = '0;
    for (int i = 0; i < N; i++) wait_off("all_dn", i, 60);
    check("final_idle", 64'(all_outs()), 64'(RST_VEC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chimera_clu_pwr_ctrl.md
# chimera_clu_pwr_ctrl

Per-cluster power/reset sequencer for the Chimera cluster domain, generalised to any number of external clusters. For each cluster it gates the cluster clock, sequences the cluster reset and drives an AXI isolation handshake, so clusters can be brought up and torn down independently at runtime. It sits in the SoC clock domain between the SoC register file (enable requests) and the cluster wrappers (clock enable, reset, isolation, wide-memory bypass).

## Interface
- NumClusters, 5, number of independently sequenced clusters (≥1)
- SettleCycles, 4, cycles clock must run before reset release (≥1)
- RstCycles, 8, cycles reset is held/observed around release and assertion (≥1)
- TimeoutCycles, 1024, isolation-handshake timeout (used only with timeout feature)
- soc_clk_i  in  1  SoC clock; all logic synchronous to it
- rst_i  in  1  asynchronous, active-high reset
- en_i  in  NumClusters  per-cluster power request (1 = on)
- widemem_bypass_i  in  NumClusters  requested wide-memory bypass setting
- isolated_i  in  NumClusters  cluster AXI isolation acknowledge (1 = fully isolated, no outstanding)
- clu_clk_en_o  out  NumClusters  clock-gate enable per cluster
- clu_rst_no  out  NumClusters  cluster reset, active-low
- isolate_o  out  NumClusters  isolation request to cluster AXI boundary
- widemem_bypass_o  out  NumClusters  latched bypass setting
- active_o  out  NumClusters  cluster in ACTIVE state
- busy_o  out  NumClusters  cluster mid-sequence (not OFF, not ACTIVE)
- timeout_o  out  NumClusters  sticky isolation-timeout flag

## Operation
- One independent FSM per cluster: OFF, CLK_ON, RST_REL, DEISO, ACTIVE, ISO, RST_ON, CLK_OFF.
- OFF: clk_en=0, rst_n=0, isolate=1. en_i=1 → CLK_ON; latch widemem_bypass_i into widemem_bypass_o on this transition.
- CLK_ON: clk_en=1; count SettleCycles cycles → RST_REL.
- RST_REL: rst_n=1, isolate=1; count RstCycles cycles → DEISO.
- DEISO: isolate=0; wait isolated_i=0 → ACTIVE.
- ACTIVE: clk_en=1, rst_n=1, isolate=0. en_i=0 → ISO.
- ISO: isolate=1; wait isolated_i=1 → RST_ON.
- RST_ON: rst_n=0, clk stays on; count RstCycles cycles → CLK_OFF.
- CLK_OFF: clk_en=0 for exactly one cycle → OFF.
- en_i is sampled only in OFF and ACTIVE; changes during transitional states are ignored until the sequence completes, then re-evaluated (en_i toggle mid-power-up → reaches ACTIVE, then immediately enters ISO next cycle).
- widemem_bypass_o changes only on OFF→CLK_ON; stable otherwise.
- Counters: one per cluster, width $clog2(max(SettleCycles,RstCycles,TimeoutCycles)+1), cleared on every state entry, no wrap (saturates).

## Timing
- Reset values: clu_clk_en_o=0, clu_rst_no=0, isolate_o=all 1, widemem_bypass_o=0, active_o=0, busy_o=0, timeout_o=0; all FSMs in OFF.
- All outputs registered (state-decoded from registered state); change one cycle after the triggering sample.
- en_i rise at cycle t → clk_en=1 at t+1; rst_n=1 at t+1+SettleCycles; isolate=0 at t+1+SettleCycles+RstCycles; active_o=1 one cycle after isolated_i is sampled low in DEISO (earliest t+2+SettleCycles+RstCycles).
- en_i fall in ACTIVE at t → isolate=1 at t+1; rst_n=0 one cycle after isolated_i sampled high; clk_en=0 RstCycles cycles later; OFF one cycle after that.
- rst_i asserted mid-sequence → all FSMs to OFF immediately (async), outputs to reset values; clock gated same instant.
- Clusters fully independent; simultaneous requests on all clusters proceed in parallel.

## Configuration
- CHIMERA_CLU_PWR_TIMEOUT_EN defined: in DEISO and ISO, if the handshake is not met within TimeoutCycles cycles, set timeout_o[i] (sticky until rst_i) and force the next transition (ACTIVE resp. RST_ON).
- Not defined: handshake states wait indefinitely; timeout_o tied 0; TimeoutCycles ignored for counter width.

## Structure
- chimera_pkg: state enum clu_pwr_state_e, default NumClusters tied to ExtClusters, default cycle constants.
- Sub-module chimera_clu_pwr_fsm: one cluster's FSM and counter, instantiated NumClusters times in a generate loop; top only fans out vectors.

## Test plan
- Power-up, defaults: en_i[0]=1 at cycle 10, isolated_i follows isolate_o with 2-cycle lag → clk_en at 11, rst_n at 15, isolate=0 at 23, active_o at 26.
- Power-down: en_i[0]=0 in ACTIVE, isolated_i rises 5 cycles after isolate → rst_n=0 one cycle after ack, clk_en=0 8 cycles later, OFF next cycle, busy_o low.
- Bypass latch: widemem_bypass_i[1]=1 at power-up, toggled while ACTIVE → widemem_bypass_o[1] stays 1 until next OFF→CLK_ON.
- Mid-sequence toggle: en_i[2] pulses for 1 cycle → full power-up to ACTIVE, then immediate ISO and full power-down.
- Timeout (macro defined, TimeoutCycles=16): isolated_i stuck 0 in ISO → timeout_o=1 after 16 cycles, FSM proceeds to RST_ON; without macro FSM stays in ISO.
- Async reset: rst_i asserted during RST_REL on all 5 clusters → all outputs at reset values within the same cycle, FSMs restart cleanly from OFF.
